// File: rtl/dram_signal_gen_if.sv
// DDR4 command/address pin bundle between the controller and the DRAM devices.
// The dram modport is driven by the signal generator; mon gives read-only access.
interface signal_gen_if #(
    parameter int RANK_BITS       = 1,
    parameter int BANK_GROUP_BITS = 2,
    parameter int BANK_BITS       = 2,
    parameter int ADDR_BITS       = 14
);
    logic                       RESET_n;
    logic                       CKE;
    logic                       CS_n;
    logic                       ACT_n;
    logic                       RAS_n_A16;
    logic                       CAS_n_A15;
    logic                       WE_n_A14;
    logic [RANK_BITS-1:0]       C;
    logic [BANK_GROUP_BITS-1:0] BG;
    logic [BANK_BITS-1:0]       BA;
    logic [ADDR_BITS-1:0]       ADDR;
    logic                       ADDR_17;
    logic                       PARITY;
    logic                       ALERT_n;
    logic                       TEN;
    logic                       ODT;
    logic                       ZQ;
    logic                       PWR;
    logic                       VREF_CA;
    logic                       VREF_DQ;

    modport dram (
        output RESET_n, CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
               C, BG, BA, ADDR, ADDR_17, PARITY,
               ALERT_n, TEN, ODT, ZQ, PWR, VREF_CA, VREF_DQ
    );

    modport mon (
        input RESET_n, CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
              C, BG, BA, ADDR, ADDR_17, PARITY,
              ALERT_n, TEN, ODT, ZQ, PWR, VREF_CA, VREF_DQ
    );
endinterface

// File: rtl/dram_signal_gen.sv
// Command-to-pin stage: runs the DDR4 power-up RESET_n/CKE sequence, then encodes
// one handshaked command per issue cycle onto the CA pins followed by a deselect gap.
module dram_signal_gen #(
    parameter int RANK_BITS       = 1,
    parameter int BANK_GROUP_BITS = 2,
    parameter int BANK_BITS       = 2,
    parameter int ROW_BITS        = 17,
    parameter int COLUMN_BITS     = 10,
    parameter int ADDR_BITS       = 14,
    parameter int T_RESET         = 16,
    parameter int T_CKE           = 32,
    parameter int T_GAP_ACT       = 3,
    parameter int T_GAP_RW        = 3,
    parameter int T_GAP_PRE       = 2,
    parameter int T_GAP_REF       = 8
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [RANK_BITS-1:0]       cmd_rank,
    input  logic [BANK_GROUP_BITS-1:0] cmd_bg,
    input  logic [BANK_BITS-1:0]       cmd_ba,
    input  logic [ROW_BITS-1:0]        cmd_row,
    input  logic [COLUMN_BITS-1:0]     cmd_col,
    input  logic                       cmd_ap,
    output logic                       init_done,
    signal_gen_if.dram                 sig
);
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ACT  = 3'd1;
    localparam logic [2:0] OP_RD   = 3'd2;
    localparam logic [2:0] OP_WR   = 3'd3;
    localparam logic [2:0] OP_PRE  = 3'd4;
    localparam logic [2:0] OP_REF  = 3'd5;
    localparam logic [2:0] OP_MRS  = 3'd6;
    localparam logic [2:0] OP_ZQCL = 3'd7;

    localparam int GAP_M1   = (T_GAP_ACT > T_GAP_RW) ? T_GAP_ACT : T_GAP_RW;
    localparam int GAP_M2   = (T_GAP_PRE > T_GAP_REF) ? T_GAP_PRE : T_GAP_REF;
    localparam int MAX_GAP  = (GAP_M1 > GAP_M2) ? GAP_M1 : GAP_M2;
    localparam int GAP_W    = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;
    localparam int INIT_MAX = (T_RESET > T_CKE) ? T_RESET : T_CKE;
    localparam int INIT_W   = $clog2(INIT_MAX + 1);

    localparam logic [INIT_W-1:0] RESET_LAST = INIT_W'(T_RESET - 1);
    localparam logic [INIT_W-1:0] CKE_LAST   = INIT_W'(T_CKE - 1);
    localparam logic [INIT_W-1:0] INIT_ZERO  = {INIT_W{1'b0}};
    localparam logic [GAP_W-1:0]  GAP_ZERO   = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0]  GAP_ONE    = GAP_W'(1);

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_CKE_WAIT   = 3'd1,
        S_IDLE       = 3'd2,
        S_ISSUE      = 3'd3,
        S_GAP        = 3'd4
    } state_t;

    state_t                     state_r, state_nxt_s;
    logic [INIT_W-1:0]          init_cnt_r, init_cnt_nxt_s;
    logic [GAP_W-1:0]           gap_cnt_r, gap_cnt_nxt_s;
    logic                       accept_s;
    logic                       reset_n_r;
    logic                       cke_r;

    logic [2:0]                 lat_op_r;
    logic [RANK_BITS-1:0]       lat_rank_r;
    logic [BANK_GROUP_BITS-1:0] lat_bg_r;
    logic [BANK_BITS-1:0]       lat_ba_r;
    logic [ROW_BITS-1:0]        lat_row_r;
    logic [COLUMN_BITS-1:0]     lat_col_r;
    logic                       lat_ap_r;

    logic                       enc_act_n_s;
    logic [2:0]                 enc_rcw_s;
    logic [ADDR_BITS-1:0]       enc_addr_s;

    logic                       pin_cs_n_r;
    logic                       pin_act_n_r;
    logic [2:0]                 pin_rcw_r;
    logic [RANK_BITS-1:0]       pin_c_r;
    logic [BANK_GROUP_BITS-1:0] pin_bg_r;
    logic [BANK_BITS-1:0]       pin_ba_r;
    logic [ADDR_BITS-1:0]       pin_addr_r;
    logic                       pin_par_r;

    function automatic logic [GAP_W-1:0] gap_of(input logic [2:0] op);
        logic [GAP_W-1:0] g;
        case (op)
            OP_ACT:                  g = GAP_W'(T_GAP_ACT);
            OP_RD, OP_WR:            g = GAP_W'(T_GAP_RW);
            OP_PRE:                  g = GAP_W'(T_GAP_PRE);
            OP_REF, OP_MRS, OP_ZQCL: g = GAP_W'(T_GAP_REF);
            default:                 g = GAP_ZERO;
        endcase
        return g;
    endfunction

    // Even parity over the CA bus; the chip-select/rank field is not covered.
    function automatic logic ca_parity(
        input logic                       act_n,
        input logic [2:0]                 rcw,
        input logic [BANK_GROUP_BITS-1:0] bg,
        input logic [BANK_BITS-1:0]       ba,
        input logic [ADDR_BITS-1:0]       addr,
        input logic                       a17
    );
        return act_n ^ (^rcw) ^ (^bg) ^ (^ba) ^ (^addr) ^ a17;
    endfunction

    // Next-state logic for the init sequence and the issue/gap handshake.
    always_comb begin
        state_nxt_s    = state_r;
        init_cnt_nxt_s = init_cnt_r;
        gap_cnt_nxt_s  = gap_cnt_r;
        accept_s       = 1'b0;
        case (state_r)
            S_RESET_HOLD: begin
                if (init_cnt_r == RESET_LAST) begin
                    state_nxt_s    = S_CKE_WAIT;
                    init_cnt_nxt_s = INIT_ZERO;
                end else begin
                    init_cnt_nxt_s = init_cnt_r + INIT_W'(1);
                end
            end
            S_CKE_WAIT: begin
                if (init_cnt_r == CKE_LAST) begin
                    state_nxt_s    = S_IDLE;
                    init_cnt_nxt_s = INIT_ZERO;
                end else begin
                    init_cnt_nxt_s = init_cnt_r + INIT_W'(1);
                end
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = S_ISSUE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (gap_of(lat_op_r) == GAP_ZERO) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    gap_cnt_nxt_s = gap_of(lat_op_r);
                    state_nxt_s   = S_GAP;
                end
            end
            S_GAP: begin
                // Only entered with a non-zero count, so the compare against one cannot wrap.
                if (gap_cnt_r <= GAP_ONE) begin
                    gap_cnt_nxt_s = GAP_ZERO;
                    state_nxt_s   = S_IDLE;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r - GAP_ONE;
                end
            end
            default: begin
                state_nxt_s = S_RESET_HOLD;
            end
        endcase
    end

    // State, counters, and the RESET_n/CKE levels that follow the next state.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_r    <= S_RESET_HOLD;
            init_cnt_r <= INIT_ZERO;
            gap_cnt_r  <= GAP_ZERO;
            reset_n_r  <= 1'b0;
            cke_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            init_cnt_r <= init_cnt_nxt_s;
            gap_cnt_r  <= gap_cnt_nxt_s;
            reset_n_r  <= (state_nxt_s != S_RESET_HOLD);
            cke_r      <= (state_nxt_s == S_IDLE) || (state_nxt_s == S_ISSUE) ||
                          (state_nxt_s == S_GAP);
        end
    end

    // Command fields captured on handshake only.
    always_ff @(posedge CLK) begin
        if (rst) begin
            lat_op_r   <= OP_NOP;
            lat_rank_r <= {RANK_BITS{1'b0}};
            lat_bg_r   <= {BANK_GROUP_BITS{1'b0}};
            lat_ba_r   <= {BANK_BITS{1'b0}};
            lat_row_r  <= {ROW_BITS{1'b0}};
            lat_col_r  <= {COLUMN_BITS{1'b0}};
            lat_ap_r   <= 1'b0;
        end else if (accept_s) begin
            lat_op_r   <= cmd_op;
            lat_rank_r <= cmd_rank;
            lat_bg_r   <= cmd_bg;
            lat_ba_r   <= cmd_ba;
            lat_row_r  <= cmd_row;
            lat_col_r  <= cmd_col;
            lat_ap_r   <= cmd_ap;
        end else begin
            lat_op_r   <= lat_op_r;
            lat_rank_r <= lat_rank_r;
            lat_bg_r   <= lat_bg_r;
            lat_ba_r   <= lat_ba_r;
            lat_row_r  <= lat_row_r;
            lat_col_r  <= lat_col_r;
            lat_ap_r   <= lat_ap_r;
        end
    end

    // DDR4 truth-table encoding of the latched command.
    always_comb begin
        enc_act_n_s = 1'b1;
        enc_rcw_s   = 3'b111;
        enc_addr_s  = {ADDR_BITS{1'b0}};
        case (lat_op_r)
            OP_ACT: begin
                enc_act_n_s = 1'b0;
                enc_rcw_s   = lat_row_r[ROW_BITS-1 -: 3];
                enc_addr_s  = lat_row_r[ADDR_BITS-1:0];
            end
            OP_RD, OP_WR: begin
                enc_rcw_s                     = (lat_op_r == OP_RD) ? 3'b101 : 3'b100;
                enc_addr_s[COLUMN_BITS-1:0]   = lat_col_r;
                enc_addr_s[10]                = lat_ap_r;
                enc_addr_s[12]                = 1'b1;
            end
            OP_PRE: begin
                enc_rcw_s      = 3'b010;
                enc_addr_s[10] = lat_ap_r;
            end
            OP_REF: begin
                enc_rcw_s = 3'b001;
            end
            OP_MRS: begin
                enc_rcw_s  = 3'b000;
                enc_addr_s = lat_row_r[ADDR_BITS-1:0];
            end
            OP_ZQCL: begin
                enc_rcw_s      = 3'b110;
                enc_addr_s[10] = 1'b1;
            end
            default: begin
                enc_rcw_s = 3'b111;
            end
        endcase
    end

    // Pin register: the encoded command for the ISSUE cycle, deselect otherwise.
    always_ff @(posedge CLK) begin
        if (rst || (state_r != S_ISSUE)) begin
            pin_cs_n_r  <= 1'b1;
            pin_act_n_r <= 1'b1;
            pin_rcw_r   <= 3'b111;
            pin_c_r     <= {RANK_BITS{1'b0}};
            pin_bg_r    <= {BANK_GROUP_BITS{1'b0}};
            pin_ba_r    <= {BANK_BITS{1'b0}};
            pin_addr_r  <= {ADDR_BITS{1'b0}};
            pin_par_r   <= 1'b0;
        end else begin
            pin_cs_n_r  <= 1'b0;
            pin_act_n_r <= enc_act_n_s;
            pin_rcw_r   <= enc_rcw_s;
            pin_c_r     <= lat_rank_r;
            pin_bg_r    <= lat_bg_r;
            pin_ba_r    <= lat_ba_r;
            pin_addr_r  <= enc_addr_s;
            pin_par_r   <= ca_parity(enc_act_n_s, enc_rcw_s, lat_bg_r, lat_ba_r,
                                     enc_addr_s, 1'b0);
        end
    end

    assign cmd_ready     = (state_r == S_IDLE);
    assign init_done     = cke_r;

    assign sig.RESET_n   = reset_n_r;
    assign sig.CKE       = cke_r;
    assign sig.CS_n      = pin_cs_n_r;
    assign sig.ACT_n     = pin_act_n_r;
    assign sig.RAS_n_A16 = pin_rcw_r[2];
    assign sig.CAS_n_A15 = pin_rcw_r[1];
    assign sig.WE_n_A14  = pin_rcw_r[0];
    assign sig.C         = pin_c_r;
    assign sig.BG        = pin_bg_r;
    assign sig.BA        = pin_ba_r;
    assign sig.ADDR      = pin_addr_r;
    assign sig.ADDR_17   = 1'b0;
    assign sig.PARITY    = pin_par_r;
    assign sig.ALERT_n   = 1'b1;
    assign sig.TEN       = 1'b0;
    assign sig.ODT       = 1'b0;
    assign sig.ZQ        = 1'b1;
    assign sig.PWR       = 1'b1;
    assign sig.VREF_CA   = 1'b1;
    assign sig.VREF_DQ   = 1'b1;
endmodule

// File: tb/tb_dram_signal_gen.sv
// Scoreboard bench for dram_signal_gen: a driver issues directed and random commands,
// a negedge monitor checks init timing, handshake spacing, pin encoding and deselect.
module tb_dram_signal_gen;
    localparam int RB  = 1;
    localparam int BGB = 2;
    localparam int BAB = 2;
    localparam int RWB = 17;
    localparam int CB  = 10;
    localparam int AB  = 14;

    localparam logic [24:0] DESEL_PINS = 25'h1E00000;
    localparam logic [24:0] DESEL_MASK = 25'h1EFFFFF;

    logic           CLK = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [2:0]     cmd_op = 3'd0;
    logic [RB-1:0]  cmd_rank = '0;
    logic [BGB-1:0] cmd_bg = '0;
    logic [BAB-1:0] cmd_ba = '0;
    logic [RWB-1:0] cmd_row = '0;
    logic [CB-1:0]  cmd_col = '0;
    logic           cmd_ap = 1'b0;
    logic           init_done;

    signal_gen_if #(.RANK_BITS(RB), .BANK_GROUP_BITS(BGB), .BANK_BITS(BAB), .ADDR_BITS(AB)) sig_if ();

    dram_signal_gen dut (
        .CLK       (CLK),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rank  (cmd_rank),
        .cmd_bg    (cmd_bg),
        .cmd_ba    (cmd_ba),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_ap    (cmd_ap),
        .init_done (init_done),
        .sig       (sig_if)
    );

    always #5 CLK = ~CLK;

    // RAS/CAS/WE levels per op (index = op); ACT takes them from the row instead.
    int RCW_TAB [8] = '{7, 0, 5, 4, 2, 1, 0, 6};
    int GAP_TAB [8] = '{0, 3, 3, 3, 2, 8, 8, 8};

    typedef struct {
        int          when;
        logic [24:0] pins;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   prev_ok = 1'b0;
    int   prev_n = 0;
    int   prev_gap = 0;
    int   first_n = -1;
    int   want_n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [24:0] model_pins(input int op, input int rank, input int bg,
                                               input int ba, input int row, input int col,
                                               input int ap);
        int addr;
        int rcw;
        int act_n;
        int par;
        rcw   = RCW_TAB[op];
        act_n = 1;
        case (op)
            1:       begin act_n = 0; rcw = row / 16384; addr = row % 16384; end
            2, 3:    addr = 4096 + ap * 1024 + col;
            4:       addr = ap * 1024;
            6:       addr = row % 16384;
            7:       addr = 1024;
            default: addr = 0;
        endcase
        par = (act_n + $countones(rcw) + $countones(bg) + $countones(ba) + $countones(addr)) % 2;
        return {act_n[0], rcw[2:0], rank[0], bg[1:0], ba[1:0], addr[13:0], 1'b0, par[0]};
    endfunction

    function automatic logic [24:0] pins_now();
        return {sig_if.ACT_n, sig_if.RAS_n_A16, sig_if.CAS_n_A15, sig_if.WE_n_A14, sig_if.C,
                sig_if.BG, sig_if.BA, sig_if.ADDR, sig_if.ADDR_17, sig_if.PARITY};
    endfunction

    // Monitor: checks pins seen this cycle, then records any handshake about to happen.
    always @(negedge CLK) begin
        if (mon_en) begin
            cyc++;
            chk("const_pins", 32'({sig_if.ALERT_n, sig_if.TEN, sig_if.ODT, sig_if.ZQ,
                                  sig_if.PWR, sig_if.VREF_CA, sig_if.VREF_DQ}), 32'h4F);
            if (sig_if.CS_n === 1'b0) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_issue @cyc %0d: got pins 0x%0h, expected deselect",
                             cyc, pins_now());
                end else begin
                    e = sb_q.pop_front();
                    chk("issue_time", cyc, e.when);
                    chk("issue_pins", 32'(pins_now()), 32'(e.pins));
                end
            end else begin
                chk("deselect_pins", 32'(pins_now() & DESEL_MASK), 32'(DESEL_PINS));
            end
            if (rst) begin
                sb_q.delete();
                prev_ok = 1'b0;
                first_n = -1;
            end else begin
                if (cmd_valid && first_n < 0) first_n = cyc;
                if (cmd_valid && cmd_ready) begin
                    if (prev_ok) begin
                        want_n = prev_n + 2 + prev_gap;
                        if (first_n > want_n) want_n = first_n;
                        chk("handshake_spacing", cyc, want_n);
                    end
                    sb_q.push_back('{when: cyc + 2,
                                     pins: model_pins(int'(cmd_op), int'(cmd_rank), int'(cmd_bg),
                                                      int'(cmd_ba), int'(cmd_row), int'(cmd_col),
                                                      int'(cmd_ap))});
                    prev_ok  = 1'b1;
                    prev_n   = cyc;
                    prev_gap = GAP_TAB[cmd_op];
                    first_n  = -1;
                end
            end
        end
    end

    task automatic do_init();
        rst = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        mon_en = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 49; i++) begin
            @(negedge CLK);
            chk("init_seq", 32'({sig_if.RESET_n, sig_if.CKE, init_done, cmd_ready}),
                32'({i >= 16, i >= 48, i >= 48, i >= 48}));
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int op, input int rank, input int bg, input int ba,
                        input int row, input int col, input int ap, input int idle);
        int t;
        repeat (idle) begin
            @(posedge CLK);
            #1;
        end
        cmd_op    = op[2:0];
        cmd_rank  = rank[RB-1:0];
        cmd_bg    = bg[BGB-1:0];
        cmd_ba    = ba[BAB-1:0];
        cmd_row   = row[RWB-1:0];
        cmd_col   = col[CB-1:0];
        cmd_ap    = ap[0];
        cmd_valid = 1'b1;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (!cmd_ready && t < 200);
        if (!cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: cmd_ready still 0 after %0d cycles, expected 1", t);
        end
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom_range(7, 0));
        cmd_rank  = RB'($urandom_range(1, 0));
        cmd_bg    = BGB'($urandom_range(3, 0));
        cmd_ba    = BAB'($urandom_range(3, 0));
        cmd_row   = RWB'($urandom_range(131071, 0));
        cmd_col   = CB'($urandom_range(1023, 0));
        cmd_ap    = 1'($urandom_range(1, 0));
    endtask

    task automatic send_rand(input int idle);
        send($urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(3, 0),
             $urandom_range(3, 0), $urandom_range(131071, 0), $urandom_range(1023, 0),
             $urandom_range(1, 0), idle);
    endtask

    initial begin
        do_init();
        send(1, 0, 2, 1, 'h1ABCD, 0, 0, 0);
        send(2, 1, 0, 3, 0, 'h155, 1, 0);
        send(3, 1, 1, 2, 0, 0, 0, 0);
        send(4, 0, 3, 0, 0, 0, 1, 0);
        send(5, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) send(0, i % 2, i, 3 - i, 'h1FFFF, 'h3FF, 1, 0);
        send(6, 1, 3, 3, 'h1FFFF, 0, 0, 1);
        send(7, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) send_rand($urandom_range(3, 0));

        send(1, 1, 3, 2, 'h0F0F0, 0, 0, 0);
        @(posedge CLK);
        #1;
        rst = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("reset_in_gap", 32'({sig_if.CS_n, sig_if.RESET_n, sig_if.CKE, cmd_ready, init_done}),
            32'h10);
        do_init();
        for (int i = 0; i < 12; i++) send_rand($urandom_range(2, 0));

        repeat (16) @(posedge CLK);
        @(negedge CLK);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
